// File: rtl/fns_dec_serial_pkg.sv
// Shared definitions for the Fibonacci-numeral-system serial codec blocks.
// Holds the FSM state encoding, the default widths and the standard FNS seeds.
package fns_pkg;

    localparam int FNS_CW_W   = 6;
    localparam int FNS_DATA_W = 8;

    // Standard FNS starts the weight sequence at 1, 1
    localparam int FNS_SEED0 = 1;
    localparam int FNS_SEED1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fns_state_e;

endpackage

// File: rtl/fns_dec_serial_if.sv
// Handshake bundle between the codeword register, the serial FNS decoder
// and the data reassembly stage. The master side supplies codewords and
// consumes results; the slave side is the decoder itself.
interface fns_dec_serial_if
    import fns_pkg::*;
#(
    parameter int CW_W   = FNS_CW_W,
    parameter int DATA_W = FNS_DATA_W
);

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   codein;
    logic [CW_W-1:0]   en_flag;
    logic [DATA_W-1:0] w0_i;
    logic [DATA_W-1:0] w1_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dataout;
    logic              busy;
    logic              err_o;

    modport master (
        output in_valid, codein, en_flag, w0_i, w1_i, out_ready,
        input  in_ready, out_valid, dataout, busy, err_o
    );

    modport slave (
        input  in_valid, codein, en_flag, w0_i, w1_i, out_ready,
        output in_ready, out_valid, dataout, busy, err_o
    );

endinterface

// File: rtl/fns_weight_gen.sv
// Running FNS weight generator. Holds the pair (wa, wb) = (W[k], W[k+1]);
// load seeds the pair, step advances it by one position of the recurrence.
// Shared between the serial decoder and the serial encoder.
module fns_weight_gen #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] weight
);

    logic [DATA_W-1:0] wa_q;
    logic [DATA_W-1:0] wb_q;

    // Seed the pair on load, otherwise slide it along W[k]=W[k-1]+W[k-2] (wraps mod 2^DATA_W)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_q <= '0;
            wb_q <= '0;
        end else if (load) begin
            wa_q <= w0;
            wb_q <= w1;
        end else if (step) begin
            wa_q <= wb_q;
            wb_q <= wa_q + wb_q;
        end
    end

    assign weight = wa_q;

endmodule

// File: rtl/fns_dec_serial.sv
// Bit-serial decoder for Fibonacci-numeral-system CAC codewords.
// Processes one codeword bit per cycle, LSB first, adding the current FNS
// weight for every enabled set bit. Weights come from programmable seeds.
// Optional feature macro: FNS_DEC_CHK_EN -- when defined, err_o flags any
// codeword with two adjacent effective ones (non-canonical FNS form).
module fns_dec_serial
    import fns_pkg::*;
#(
    parameter int CW_W   = FNS_CW_W,
    parameter int DATA_W = FNS_DATA_W,
    parameter int CNT_W  = $clog2(CW_W)
) (
    input  logic           clk,
    input  logic           rst_n,
    fns_dec_serial_if.slave bus
);

    fns_state_e        state_q;
    fns_state_e        state_next;

    logic [CW_W-1:0]   code_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  idx_q;
    logic [DATA_W-1:0] dataout_q;

    logic              in_ready_c;
    logic              accept;
    logic              running;
    logic              cur_bit;
    logic              last_bit;
    logic [DATA_W-1:0] weight;
    logic [DATA_W-1:0] sum_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and handshake decode; DONE can hand straight over to a new bundle
    always_comb begin
        state_next = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = bus.in_valid ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign accept    = in_ready_c & bus.in_valid;
    assign running   = (state_q == ST_RUN);
    assign cur_bit   = code_q[idx_q];
    assign last_bit  = running && (idx_q == CNT_W'(CW_W - 1));
    assign sum_next  = acc_q + (cur_bit ? weight : '0);

    fns_weight_gen #(
        .DATA_W (DATA_W)
    ) u_weight_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (running),
        .w0     (bus.w0_i),
        .w1     (bus.w1_i),
        .weight (weight)
    );

    // Capture the masked codeword on acceptance, then accumulate one bit per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            dataout_q <= '0;
        end else if (accept) begin
            code_q <= bus.codein & bus.en_flag;
            acc_q  <= '0;
            idx_q  <= '0;
        end else if (running) begin
            acc_q <= sum_next;
            idx_q <= idx_q + CNT_W'(1);
            if (last_bit) begin
                dataout_q <= sum_next;
            end
        end
    end

`ifdef FNS_DEC_CHK_EN
    logic prev_q;
    logic err_acc_q;
    logic err_q;
    logic err_next;

    assign err_next = err_acc_q | (prev_q & cur_bit);

    // Track the previous effective bit and latch the adjacency error alongside dataout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 1'b0;
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            prev_q    <= 1'b0;
            err_acc_q <= 1'b0;
        end else if (running) begin
            prev_q    <= cur_bit;
            err_acc_q <= err_next;
            if (last_bit) begin
                err_q <= err_next;
            end
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.dataout   = dataout_q;

endmodule

// File: tb/tb_fns_dec_serial.sv
// Self-checking bench for fns_dec_serial. Results are compared with a
// behavioural FNS model (explicit weight table, plain sums modulo 2^DATA_W).
// A second instance with DATA_W=4 exercises accumulator wrap-around.
module tb_fns_dec_serial;

    logic clk;
    logic rst_n;

    int checks;
    int fails;

    fns_dec_serial_if #(.CW_W(6), .DATA_W(8)) bus ();
    fns_dec_serial_if #(.CW_W(6), .DATA_W(4)) sbus ();

    fns_dec_serial #(.CW_W(6), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fns_dec_serial #(.CW_W(6), .DATA_W(4)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decoder: build the weight table, sum weights of effective ones, wrap to dw bits
    function automatic int ref_value(input logic [5:0] c, input logic [5:0] en,
                                     input int w0, input int w1, input int dw);
        int w[6];
        int s;
        w[0] = w0;
        w[1] = w1;
        for (int k = 2; k < 6; k++) w[k] = w[k-1] + w[k-2];
        s = 0;
        for (int k = 0; k < 6; k++) if (c[k] && en[k]) s = s + w[k];
        return s % (1 << dw);
    endfunction

    // Reference error flag: two neighbouring effective ones mean a non-canonical codeword
    function automatic logic ref_err(input logic [5:0] c, input logic [5:0] en);
        logic e;
        e = 1'b0;
`ifdef FNS_DEC_CHK_EN
        for (int k = 0; k < 5; k++) if (c[k] && en[k] && c[k+1] && en[k+1]) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle and hold it until the accepting edge has passed
    task automatic applyStimulus(input logic [5:0] c, input logic [5:0] en,
                                 input logic [7:0] w0, input logic [7:0] w1);
        int guard;
        bus.codein   = c;
        bus.en_flag  = en;
        bus.w0_i     = w0;
        bus.w1_i     = w1;
        bus.in_valid = 1'b1;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 40) begin
            tick();
            guard++;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count cycles from the accepting edge until out_valid, bounded
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_flags: got valid=%b busy=%b err=%b expected 0/0/0",
                     bus.out_valid, bus.busy, bus.err_o);
        end
        checks++;
        if (bus.dataout !== 8'd0 || sbus.dataout !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_dataout: got %0d/%0d expected 0/0", bus.dataout, sbus.dataout);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        logic [7:0] exp;
        exp = 8'(ref_value(6'b101010, 6'b111111, 1, 1, 8));
        bus.out_ready = 1'b1;
        applyStimulus(6'b101010, 6'b111111, 8'd1, 8'd1);
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_run_flags: got busy=%b in_ready=%b expected 1/0", bus.busy, bus.in_ready);
        end
        wait_result(cyc);
        checks++;
        if (cyc !== 6) begin
            fails++;
            $display("[TB] FAIL basic_latency: got %0d cycles expected 6", cyc);
        end
        checks++;
        if (bus.dataout !== exp) begin
            fails++;
            $display("[TB] FAIL basic_value: got %0d expected %0d", bus.dataout, exp);
        end
        checks++;
        if (bus.err_o !== ref_err(6'b101010, 6'b111111)) begin
            fails++;
            $display("[TB] FAIL basic_err: got %b expected %b", bus.err_o, ref_err(6'b101010, 6'b111111));
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_release: got valid=%b busy=%b expected 0/0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_enable_mask();
        int cyc;
        logic [7:0] exp;
        exp = 8'(ref_value(6'b111111, 6'b000111, 1, 1, 8));
        applyStimulus(6'b111111, 6'b000111, 8'd1, 8'd1);
        wait_result(cyc);
        checks++;
        if (bus.dataout !== exp || cyc !== 6) begin
            fails++;
            $display("[TB] FAIL mask_value: got %0d after %0d cycles expected %0d after 6", bus.dataout, cyc, exp);
        end
        checks++;
        if (bus.err_o !== ref_err(6'b111111, 6'b000111)) begin
            fails++;
            $display("[TB] FAIL mask_err: got %b expected %b", bus.err_o, ref_err(6'b111111, 6'b000111));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_adapted_seeds();
        int cyc;
        logic [7:0] exp;
        exp = 8'(ref_value(6'b100001, 6'b111111, 2, 3, 8));
        applyStimulus(6'b100001, 6'b111111, 8'd2, 8'd3);
        bus.w0_i = 8'd77;
        bus.w1_i = 8'd91;
        wait_result(cyc);
        checks++;
        if (bus.dataout !== exp || cyc !== 6) begin
            fails++;
            $display("[TB] FAIL seeds_value: got %0d after %0d cycles expected %0d after 6", bus.dataout, cyc, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int cyc;
        logic [3:0] exp;
        exp = 4'(ref_value(6'b111111, 6'b111111, 1, 1, 4));
        sbus.codein   = 6'b111111;
        sbus.en_flag  = 6'b111111;
        sbus.w0_i     = 4'd1;
        sbus.w1_i     = 4'd1;
        sbus.in_valid = 1'b1;
        tick();
        sbus.in_valid = 1'b0;
        cyc = 0;
        while (!sbus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (sbus.dataout !== exp || cyc !== 6) begin
            fails++;
            $display("[TB] FAIL overflow_value: got %0d after %0d cycles expected %0d after 6", sbus.dataout, cyc, exp);
        end
        sbus.out_ready = 1'b1;
        tick();
        sbus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        exp_a = 8'(ref_value(6'b010101, 6'b111111, 5, 9, 8));
        exp_b = 8'(ref_value(6'b001001, 6'b111111, 3, 4, 8));
        applyStimulus(6'b010101, 6'b111111, 8'd5, 8'd9);
        wait_result(cyc);
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.dataout !== exp_a) begin
                fails++;
                $display("[TB] FAIL hold_%0d: got valid=%b in_ready=%b data=%0d expected 1/0/%0d",
                         h, bus.out_valid, bus.in_ready, bus.dataout, exp_a);
            end
            tick();
        end
        bus.codein    = 6'b001001;
        bus.en_flag   = 6'b111111;
        bus.w0_i      = 8'd3;
        bus.w1_i      = 8'd4;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.dataout !== exp_a) begin
            fails++;
            $display("[TB] FAIL handover_ready: got in_ready=%b data=%0d expected 1/%0d", bus.in_ready, bus.dataout, exp_a);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL handover_run: got busy=%b valid=%b expected 1/0", bus.busy, bus.out_valid);
        end
        wait_result(cyc);
        checks++;
        if (bus.dataout !== exp_b || cyc !== 6) begin
            fails++;
            $display("[TB] FAIL b2b_value: got %0d after %0d cycles expected %0d after 6", bus.dataout, cyc, exp_b);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int cyc;
        int hold;
        logic [5:0] c;
        logic [5:0] en;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] exp;
        logic exp_err;
        for (int i = 0; i < 20; i++) begin
            c       = 6'($urandom);
            en      = 6'($urandom);
            w0      = 8'($urandom);
            w1      = 8'($urandom);
            exp     = 8'(ref_value(c, en, int'(w0), int'(w1), 8));
            exp_err = ref_err(c, en);
            applyStimulus(c, en, w0, w1);
            bus.w0_i    = 8'($urandom);
            bus.w1_i    = 8'($urandom);
            bus.codein  = 6'($urandom);
            bus.in_valid = 1'($urandom);
            wait_result(cyc);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.dataout !== exp || bus.err_o !== exp_err || cyc !== 6) begin
                fails++;
                $display("[TB] FAIL random_%0d: got data=%0d err=%b after %0d cycles expected %0d/%b after 6 (c=%b en=%b w=%0d,%0d)",
                         i, bus.dataout, bus.err_o, cyc, exp, exp_err, c, en, w0, w1);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) tick();
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [7:0] exp;
        applyStimulus(6'b111011, 6'b111111, 8'd7, 8'd11);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.dataout !== 8'd0 || bus.busy !== 1'b0 || bus.err_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrun_reset: got valid=%b data=%0d busy=%b err=%b expected 0/0/0/0",
                     bus.out_valid, bus.dataout, bus.busy, bus.err_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        exp = 8'(ref_value(6'b000100, 6'b111111, 1, 1, 8));
        applyStimulus(6'b000100, 6'b111111, 8'd1, 8'd1);
        wait_result(cyc);
        checks++;
        if (bus.dataout !== exp || cyc !== 6) begin
            fails++;
            $display("[TB] FAIL post_reset_value: got %0d after %0d cycles expected %0d after 6", bus.dataout, cyc, exp);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // Test sequence
    initial begin
        checks         = 0;
        fails          = 0;
        rst_n          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.codein     = '0;
        bus.en_flag    = '0;
        bus.w0_i       = '0;
        bus.w1_i       = '0;
        sbus.in_valid  = 1'b0;
        sbus.out_ready = 1'b0;
        sbus.codein    = '0;
        sbus.en_flag   = '0;
        sbus.w0_i      = '0;
        sbus.w1_i      = '0;
        #2;
        test_reset();
        test_basic();
        test_enable_mask();
        test_adapted_seeds();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fns_dec_serial.md
Name: fns_dec_serial

Overview:
- Parametrised, bit-serial decoder for Fibonacci-numeral-system (FNS) CAC codewords.
- Converts a CW_W-bit codeword into a DATA_W-bit binary value. Each enabled set bit contributes its FNS weight.
- Weights are generated on the fly from two programmable seeds (w0_i, w1_i), so one block serves both standard FNS and locally adapted FNS.
- Sits on the receive side of the bus, behind the codeword register and ahead of the data reassembly stage. Uses a valid/ready handshake on both sides.

Parameters:
- CW_W, 6, codeword width in bits; legal range is 2 or more.
- DATA_W, 8, width of decoded output, seeds and accumulator.
- CNT_W, $clog2(CW_W), width of the bit-index counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  codeword/enable/seed bundle is valid.
- in_ready  out  1  block can accept a bundle this cycle.
- codein  in  CW_W  codeword; bit k has weight W[k].
- en_flag  in  CW_W  per-bit enable; the effective bit is codein[k] AND en_flag[k].
- w0_i  in  DATA_W  seed weight W[0].
- w1_i  in  DATA_W  seed weight W[1].
- out_valid  out  1  dataout/err_o hold a result.
- out_ready  in  1  downstream accepts the result.
- dataout  out  DATA_W  decoded value, sum of W[k] over all effective set bits.
- busy  out  1  high in RUN or DONE.
- err_o  out  1  invalid-codeword flag (see Optional Feature).

Behaviour:
- Weight recurrence: W[0]=w0_i, W[1]=w1_i, W[k]=W[k-1]+W[k-2]. All weight and accumulator arithmetic is modulo 2^DATA_W; overflow wraps silently.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1 (IDLE); out_valid=0, dataout=0, busy=0, err_o=0.
  - Internal code, mask, weight pair, accumulator and counter are cleared.
  - Reset mid-RUN or mid-DONE discards the operation; no partial result appears after reset.
- State IDLE:
  - in_ready=1.
  - On in_valid: capture code = codein & en_flag, wa=w0_i, wb=w1_i, acc=0, idx=0; go to RUN.
- State RUN, one bit per cycle, LSB first:
  - acc <= acc + (code[idx] ? wa : 0).
  - (wa, wb) <= (wb, wa+wb).
  - idx <= idx+1.
  - On the cycle that processes idx==CW_W-1, register the final sum into dataout and go to DONE.
  - in_ready=0 throughout RUN.
- State DONE:
  - out_valid=1; dataout and err_o are held stable until out_ready.
  - On out_ready: if in_valid is also high, accept the new bundle in the same cycle and go straight to RUN (in_ready = out_ready in DONE). Otherwise go to IDLE.
- Timing:
  - Latency: out_valid rises exactly CW_W cycles after the accepting edge.
  - Throughput under continuous traffic with out_ready=1: one codeword per CW_W+1 cycles.
- Edge cases:
  - All-zero effective code gives dataout=0.
  - Seed changes after acceptance have no effect until the next acceptance.
  - in_valid deasserted while in_ready=0 is legal and ignored.
  - out_ready high outside DONE is ignored.

Optional Feature:
- Macro: FNS_DEC_CHK_EN.
- Defined: during RUN the block tracks the previous effective bit. err_o is registered with dataout and is 1 if any two adjacent effective bits (k, k+1) are both 1, i.e. a non-canonical FNS codeword. The decoded value is still produced normally.
- Undefined: err_o is tied to 0 and no checking logic is built.

Decomposition:
- Shared package fns_pkg:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE;
  - default CW_W/DATA_W;
  - standard seed constants FNS_SEED0=1, FNS_SEED1=1.
- One sub-module, fns_weight_gen: holds the (wa, wb) pair with load and step inputs and outputs the current weight. It is reused by the future serial encoder.

Test Plan:
- Basic decode: seeds 1/1, codein=6'b101010, en_flag=6'b111111, out_ready=1 -> dataout=12 (1+3+8); out_valid rises 6 cycles after acceptance; err_o=0.
- Enable mask: codein=6'b111111, en_flag=6'b000111 -> dataout=4 (1+1+2). With FNS_DEC_CHK_EN, err_o=1.
- Adapted seeds: w0_i=2, w1_i=3, codein=6'b100001 -> weights 2,3,5,8,13,21; dataout=23.
- Overflow: DATA_W=4, seeds 1/1, codein=all ones, en all ones -> dataout=4 (20 mod 16).
- Back-to-back with backpressure: hold out_ready=0 for 3 cycles in DONE -> dataout stable and in_ready=0 during the hold. Then assert out_ready with in_valid=1 -> new bundle accepted in the same cycle and next out_valid 6 cycles later.
- Reset mid-RUN: pull rst_n low 3 cycles after acceptance -> out_valid=0 and dataout=0 immediately. After release, a new codeword 6'b000100 decodes to 2 with no stale contribution.
